// File: rtl/jtcop_irqctl.sv
// 68000 interrupt controller: N latched sources (edge/level, polarity, IPL level) with CPU mask and registered IPLn.
// Latency: irq_in -> pend 2 clk, -> IPLn 3 clk; clr/mask_we -> IPLn 2 clk. No backpressure.
// Optional JTCOP_IRQ_ACKCLR_EN: the IACK rising edge clears the acknowledged edge source.
module jtcop_irqctl #(
    parameter int                N      = 4,
    parameter logic [3*N-1:0]    LEVELS = {3'd0, 3'd4, 3'd5, 3'd6},
    parameter logic [N-1:0]      EDGE   = 4'b0111,
    parameter logic [N-1:0]      POL    = 4'b1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] irq_in,
    input  logic [N-1:0] clr,
    input  logic         mask_we,
    input  logic [N-1:0] mask_din,
    input  logic         iack,
    input  logic [2:0]   iack_lvl,
    output logic [2:0]   IPLn,
    output logic [N-1:0] pend
);

    if (N < 1 || N > 8) begin : g_bad_n
        $error("jtcop_irqctl: N must be in 1..8");
    end

    logic [N-1:0] act;
    logic [N-1:0] irq_s;
    logic [N-1:0] irq_l;
    logic [N-1:0] mask;
    logic [N-1:0] rise;
    logic [N-1:0] ack_clr;
    logic [N-1:0] pend_nxt;
    logic [2:0]   lvl;

    assign act  = irq_in ^ POL;
    assign rise = irq_s & ~irq_l;

    // Clear beats a same-cycle set on edge sources; level sources simply follow irq_s.
    assign pend_nxt = (EDGE & (pend | rise) & ~(clr | ack_clr)) | (~EDGE & irq_s);

    always_comb begin
        lvl = 3'd0;
        for (int i = 0; i < N; i++) begin
            if (pend[i] && !mask[i] && LEVELS[3*i +: 3] > lvl) begin
                lvl = LEVELS[3*i +: 3];
            end
        end
    end

`ifdef JTCOP_IRQ_ACKCLR_EN
    logic iack_l;
    logic ack_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            iack_l <= 1'b0;
        end else begin
            iack_l <= iack;
        end
    end

    // Only the lowest-index pending, unmasked edge source at the acknowledged level is cleared.
    always_comb begin
        ack_clr = '0;
        ack_hit = 1'b0;
        if (iack && !iack_l && iack_lvl == ~IPLn && iack_lvl != 3'd0) begin
            for (int i = 0; i < N; i++) begin
                if (!ack_hit && EDGE[i] && pend[i] && !mask[i] && LEVELS[3*i +: 3] == iack_lvl) begin
                    ack_clr[i] = 1'b1;
                    ack_hit    = 1'b1;
                end
            end
        end
    end
`else
    logic unused_iack;

    assign unused_iack = ^{iack, iack_lvl};
    assign ack_clr     = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_s <= '0;
            irq_l <= '0;
            pend  <= '0;
            mask  <= '0;
            IPLn  <= 3'b111;
        end else begin
            irq_s <= act;
            irq_l <= irq_s;
            pend  <= pend_nxt;
            IPLn  <= ~lvl;
            if (mask_we) begin
                mask <= mask_din;
            end
        end
    end

endmodule
